audio_dma_arbiter: RTL and testbench
====================================

# audio_dma_arbiter

Shares one 32-bit DMA bus-master port between `CHANNELS` audio channel DMA engines. It sits between the per-channel request/ready pairs and the system bus. It grants channels round-robin and holds one transaction in flight at a time. It returns read data to the granted channel and aborts stalled bus cycles with a timeout, so one hung transfer cannot starve the other channels.

## Interface
Parameters:
- `CHANNELS`, 4: number of requesting channels (2..8).
- `TIMEOUT`, 1023: bus cycles to wait for `i_bus_ready` before aborting.

Ports:
- `i_clock`  in  1  sole clock.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_enable`  in  1  when low, no new grants are issued; an in-flight transaction still completes.
- `i_ch_request`  in  CHANNELS  per-channel DMA request, level.
- `i_ch_address`  in  CHANNELS×32  per-channel word address. Valid while the matching request is high.
- `o_ch_ready`  out  CHANNELS  one-hot, single-cycle completion pulse.
- `o_ch_rdata`  out  32  read data, broadcast to all channels. Registered.
- `o_bus_request`  out  1  bus-master request.
- `o_bus_address`  out  32  bus address.
- `i_bus_ready`  in  1  bus completion strobe.
- `i_bus_rdata`  in  32  bus read data, valid with `i_bus_ready`.
- `o_grant`  out  $clog2(CHANNELS)  index of the current or last granted channel.
- `o_timeout`  out  1  single-cycle pulse when a transaction is aborted.
- `o_timeout_count`  out  16  saturating count of aborts.

## Operation
- FSM states and transitions:
  - IDLE → BUS when `i_enable` is high and any `i_ch_request` bit is set.
  - BUS → DONE on `i_bus_ready`, or when the timeout counter reaches `TIMEOUT-1`.
  - DONE → IDLE unconditionally.
- Round-robin selection in IDLE:
  - Search starts at index `last_grant+1` and wraps modulo `CHANNELS`.
  - The first set request wins.
  - On entering BUS, `last_grant` and `o_grant` are updated to the winner.
- On the IDLE→BUS edge, the winner's address is latched into `o_bus_address`, and `o_bus_request` is set to 1.
- BUS state:
  - `o_bus_request` and `o_bus_address` are held constant.
  - The timeout counter increments each cycle.
  - A change of `i_ch_request` or `i_ch_address` is ignored.
- Normal completion (BUS with `i_bus_ready` = 1):
  - `i_bus_rdata` is latched into `o_ch_rdata`.
  - `o_bus_request` is set to 0.
  - Next state is DONE.
- Timeout completion (BUS, counter == `TIMEOUT-1`, no ready):
  - `o_ch_rdata` is set to 0 (silence sample).
  - `o_bus_request` is set to 0.
  - `o_timeout` pulses.
  - `o_timeout_count` increments and saturates at 0xFFFF.
  - Next state is DONE.
- If `i_bus_ready` arrives in the same cycle the counter hits its limit, it counts as normal completion. No timeout is flagged.
- DONE state:
  - `o_ch_ready[o_grant]` is 1 for exactly this cycle.
  - `o_ch_rdata` stays stable until the next completion, which is at least 3 cycles later. A channel may therefore sample it one cycle after ready.
- A granted channel that drops its request during BUS still receives its ready pulse.
- `i_bus_ready` outside BUS is ignored.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - `last_grant` = CHANNELS-1, so channel 0 wins the first arbitration.
  - The timeout counter is 0.
- Latency:
  - Request visible in IDLE at cycle 0 → `o_bus_request` high at cycle 1.
  - `i_bus_ready` at cycle k → `o_ch_ready` at k+1 → IDLE at k+2 → next `o_bus_request` at k+3 at the earliest.
- Fairness: with all channels requesting continuously, grants are 0,1,2,…,CHANNELS-1,0,…
- No channel is granted twice while another has a request pending at arbitration time.
- Reset asserted mid-transaction drops `o_bus_request` immediately and asynchronously. No ready pulse is issued.

## Structure
- Package `audio_pkg`:
  - `audio_arb_state_t` enum {IDLE, BUS, DONE}.
  - `audio_addr_t` (32-bit).
  - `AUDIO_SILENCE` (32'h0).
- Sub-module `audio_rr_picker`: combinational rotate/priority-encode/rotate-back.
  - Inputs: request vector, last grant.
  - Outputs: `valid` and winner index.
  - Reused by a future mixer scheduler.

## Test plan
- Single channel: ch2 requests address 0x1000, bus ready after 3 cycles with 0xA5A5_5A5A → `o_bus_address`=0x1000; `o_ch_ready`=4'b0100 for one cycle; `o_ch_rdata`=0xA5A5_5A5A held ≥2 cycles.
- All four channels requesting continuously, bus ready 1 cycle after request → grant order 0,1,2,3,0,1; per-transaction spacing 4 cycles.
- TIMEOUT=8, bus never ready → `o_bus_request` drops after 8 BUS cycles; `o_timeout` pulses; `o_ch_rdata`=0; count=1; next channel is served.
- Ready coincident with the final timeout cycle → normal completion with bus data; `o_timeout` stays 0; count unchanged.
- `i_enable`=0 during BUS: in-flight transaction completes with a ready pulse, then no further grants. Async reset mid-BUS: all outputs 0 within the same cycle; after release, ch0 is granted first.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg
//   Types and constants shared by the audio DMA arbiter and its helpers.
//   - audio_arb_state_t : arbiter FSM encoding (IDLE -> BUS -> DONE -> IDLE)
//   - audio_addr_t      : 32-bit bus word address
//   - AUDIO_SILENCE     : sample returned to a channel when its bus cycle is aborted
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } audio_arb_state_t;

  typedef logic [31:0] audio_addr_t;

  localparam logic [31:0] AUDIO_SILENCE = 32'h0;

endpackage

// File: rtl/audio_rr_picker.sv
// audio_rr_picker
//   Combinational round-robin picker. The request vector is rotated so the
//   channel after last_grant sits at bit 0, the lowest set bit is found, and
//   the offset is rotated back into an absolute channel index.
//   Ports:
//     request    in  CHANNELS          request vector
//     last_grant in  $clog2(CHANNELS)  previously granted index
//     valid      out 1                 at least one request is set
//     winner     out $clog2(CHANNELS)  index of the winning channel
module audio_rr_picker #(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]         request,
  input  logic [$clog2(CHANNELS)-1:0] last_grant,
  output logic                        valid,
  output logic [$clog2(CHANNELS)-1:0] winner
);

  localparam int GW = $clog2(CHANNELS);

  logic [2*CHANNELS-1:0] doubled;
  logic [CHANNELS-1:0]   rotated;
  logic [GW-1:0]         offset;
  int                    start;

  always_comb begin
    start   = (int'(last_grant) + 1) % CHANNELS;
    // Doubling the vector turns the rotate into a plain right shift.
    doubled = {request, request};
    rotated = CHANNELS'(doubled >> start);
    offset  = '0;
    // Scan downwards so the lowest set bit is the one left standing.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = GW'(i);
      end
    end
    valid  = |request;
    winner = GW'((int'(offset) + start) % CHANNELS);
  end

endmodule

// File: rtl/audio_dma_arbiter.sv
// audio_dma_arbiter
//   Shares one 32-bit DMA bus-master port between CHANNELS audio DMA engines.
//   Channels are granted round-robin, one bus transaction is in flight at a
//   time, and a bus cycle that is not acknowledged within TIMEOUT cycles is
//   aborted and answered with a silence sample.
//
//   Handshake: a channel holds i_ch_request (level) with a stable
//   i_ch_address until it sees its bit of o_ch_ready, a one-cycle pulse.
//   Towards the bus, o_bus_request and o_bus_address are held stable until
//   the cycle i_bus_ready is seen high (i_bus_rdata valid in that cycle) or
//   the timeout fires; a channel's request is sampled only at arbitration.
//
//   Ports:
//     i_clock, i_reset      clock, asynchronous active-high reset
//     i_enable              gates new grants; an in-flight transfer finishes
//     i_ch_request          per-channel request
//     i_ch_address          per-channel word address
//     o_ch_ready            one-hot completion pulse (DONE state)
//     o_ch_rdata            registered read data, broadcast to all channels
//     o_bus_request         bus-master request
//     o_bus_address         bus address, latched at grant
//     i_bus_ready           bus completion strobe
//     i_bus_rdata           bus read data
//     o_grant               current or last granted channel
//     o_timeout             one-cycle pulse when a transfer is aborted
//     o_timeout_count       saturating abort counter
//     o_state               FSM state, for debug and checkers
module audio_dma_arbiter
  import audio_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [CHANNELS-1:0]           i_ch_request,
  input  logic [CHANNELS-1:0][31:0]     i_ch_address,
  output logic [CHANNELS-1:0]           o_ch_ready,
  output logic [31:0]                   o_ch_rdata,
  output logic                          o_bus_request,
  output logic [31:0]                   o_bus_address,
  input  logic                          i_bus_ready,
  input  logic [31:0]                   i_bus_rdata,
  output logic [$clog2(CHANNELS)-1:0]   o_grant,
  output logic                          o_timeout,
  output logic [15:0]                   o_timeout_count,
  output audio_arb_state_t              o_state
);

  localparam int GW = $clog2(CHANNELS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CHANNELS-1:0] ONE_HOT0 = {{(CHANNELS-1){1'b0}}, 1'b1};

  audio_arb_state_t state;
  logic [GW-1:0]    last_grant;
  logic [CW-1:0]    tmo_cnt;
  logic             pick_valid;
  logic [GW-1:0]    pick;

  audio_rr_picker #(
    .CHANNELS (CHANNELS)
  ) u_picker (
    .request    (i_ch_request),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick)
  );

  assign o_state = state;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state           <= IDLE;
      // Channel 0 wins the first arbitration after reset.
      last_grant      <= GW'(CHANNELS - 1);
      tmo_cnt         <= '0;
      o_ch_ready      <= '0;
      o_ch_rdata      <= '0;
      o_bus_request   <= 1'b0;
      o_bus_address   <= '0;
      o_grant         <= '0;
      o_timeout       <= 1'b0;
      o_timeout_count <= '0;
    end else begin
      // Pulses default low; they are raised only on the BUS->DONE edge.
      o_ch_ready <= '0;
      o_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable && pick_valid) begin
            state         <= BUS;
            last_grant    <= pick;
            o_grant       <= pick;
            o_bus_address <= i_ch_address[pick];
            o_bus_request <= 1'b1;
            tmo_cnt       <= '0;
          end
        end
        BUS: begin
          // A ready arriving on the last allowed cycle is a normal completion.
          if (i_bus_ready) begin
            state         <= DONE;
            o_ch_rdata    <= i_bus_rdata;
            o_bus_request <= 1'b0;
            o_ch_ready    <= ONE_HOT0 << o_grant;
          end else if (tmo_cnt == TMO_LAST) begin
            state         <= DONE;
            o_ch_rdata    <= AUDIO_SILENCE;
            o_bus_request <= 1'b0;
            o_ch_ready    <= ONE_HOT0 << o_grant;
            o_timeout     <= 1'b1;
            if (o_timeout_count != 16'hFFFF) begin
              o_timeout_count <= o_timeout_count + 16'd1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dma_arbiter.sv
module tb_audio_dma_arbiter;
  import audio_pkg::*;

  localparam int CHANNELS = 4;
  localparam int TIMEOUT  = 8;

  logic                      i_clock;
  logic                      i_reset;
  logic                      i_enable;
  logic [CHANNELS-1:0]       ch_request;
  logic [CHANNELS-1:0][31:0] ch_address;
  logic [CHANNELS-1:0]       ch_ready;
  logic [31:0]               ch_rdata;
  logic                      bus_request;
  logic [31:0]               bus_address;
  logic                      bus_ready;
  logic [31:0]               bus_rdata;
  logic [1:0]                grant;
  logic                      timeout;
  logic [15:0]               timeout_count;
  audio_arb_state_t          dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int prev_cyc = 0;
  int n_wait   = 0;

  audio_dma_arbiter #(
    .CHANNELS (CHANNELS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_ch_request    (ch_request),
    .i_ch_address    (ch_address),
    .o_ch_ready      (ch_ready),
    .o_ch_rdata      (ch_rdata),
    .o_bus_request   (bus_request),
    .o_bus_address   (bus_address),
    .i_bus_ready     (bus_ready),
    .i_bus_rdata     (bus_rdata),
    .o_grant         (grant),
    .o_timeout       (timeout),
    .o_timeout_count (timeout_count),
    .o_state         (dbg_state)
  );

  // Clock / reset
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Drivers: advance one clock, land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_bus_request(input int budget);
    n_wait = 0;
    while (!bus_request && n_wait < budget) begin
      tick();
      n_wait++;
    end
  endtask

  initial begin
    i_reset    = 1'b1;
    i_enable   = 1'b1;
    ch_request = '0;
    ch_address = '0;
    bus_ready  = 1'b0;
    bus_rdata  = '0;
    tick();
    tick();

    // ---- reset values
    check("rst_bus_request", bus_request, 1'b0);
    check("rst_bus_address", bus_address, 32'h0);
    check("rst_ch_ready", ch_ready, 4'b0000);
    check("rst_ch_rdata", ch_rdata, 32'h0);
    check("rst_grant", grant, 2'd0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_timeout_count", timeout_count, 16'h0);
    check("rst_state", dbg_state, IDLE);
    i_reset = 1'b0;
    tick();
    check("idle_no_req", bus_request, 1'b0);

    // ---- single channel: ch2 @ 0x1000, bus ready on its 4th BUS cycle
    ch_request    = 4'b0100;
    ch_address[2] = 32'h0000_1000;
    tick();
    check("t1_bus_request", bus_request, 1'b1);
    check("t1_bus_address", bus_address, 32'h0000_1000);
    check("t1_grant", grant, 2'd2);
    ch_address[2] = 32'h0000_DEAD;
    tick();
    tick();
    check("t1_addr_held", bus_address, 32'h0000_1000);
    check("t1_req_held", bus_request, 1'b1);
    tick();
    bus_ready = 1'b1;
    bus_rdata = 32'hA5A5_5A5A;
    tick();
    bus_ready  = 1'b0;
    bus_rdata  = 32'h0;
    ch_request = 4'b0000;
    check("t1_ch_ready", ch_ready, 4'b0100);
    check("t1_rdata", ch_rdata, 32'hA5A5_5A5A);
    check("t1_req_dropped", bus_request, 1'b0);
    check("t1_state_done", dbg_state, DONE);
    tick();
    check("t1_ready_single", ch_ready, 4'b0000);
    check("t1_rdata_hold1", ch_rdata, 32'hA5A5_5A5A);
    tick();
    check("t1_rdata_hold2", ch_rdata, 32'hA5A5_5A5A);
    check("t1_no_regrant", bus_request, 1'b0);

    // ---- fairness from reset: all four requesting, ready one cycle after request
    i_reset = 1'b1;
    tick();
    i_reset    = 1'b0;
    ch_request = 4'b1111;
    for (int i = 0; i < CHANNELS; i++) ch_address[i] = 32'h0000_0040 + 32'h100 * i;
    for (int t = 0; t < 6; t++) begin
      wait_bus_request(8);
      check($sformatf("t2_req_%0d", t), bus_request, 1'b1);
      check($sformatf("t2_grant_%0d", t), grant, t % CHANNELS);
      check($sformatf("t2_addr_%0d", t), bus_address, 32'h0000_0040 + 32'h100 * (t % CHANNELS));
      if (t > 0) check($sformatf("t2_spacing_%0d", t), cyc - prev_cyc, 4);
      prev_cyc = cyc;
      tick();
      bus_ready = 1'b1;
      bus_rdata = 32'hC0DE_0000 + t;
      tick();
      bus_ready = 1'b0;
      check($sformatf("t2_ready_%0d", t), ch_ready, 4'b0001 << (t % CHANNELS));
      check($sformatf("t2_rdata_%0d", t), ch_rdata, 32'hC0DE_0000 + t);
      if (t == 5) ch_request = 4'b0000;
    end
    tick();

    // ---- timeout: ch2 and ch3 request, bus never answers ch2
    ch_request    = 4'b1100;
    ch_address[2] = 32'h0000_2000;
    ch_address[3] = 32'h0000_3000;
    tick();
    check("t3_grant", grant, 2'd2);
    check("t3_addr", bus_address, 32'h0000_2000);
    for (int i = 2; i <= TIMEOUT; i++) tick();
    check("t3_req_last_cycle", bus_request, 1'b1);
    check("t3_no_early_timeout", timeout, 1'b0);
    tick();
    check("t3_req_dropped", bus_request, 1'b0);
    check("t3_timeout_pulse", timeout, 1'b1);
    check("t3_ch_ready", ch_ready, 4'b0100);
    check("t3_silence", ch_rdata, 32'h0);
    check("t3_count", timeout_count, 16'd1);
    ch_request = 4'b1000;
    tick();
    check("t3_timeout_single", timeout, 1'b0);
    tick();
    check("t3_next_req", bus_request, 1'b1);
    check("t3_next_grant", grant, 2'd3);
    check("t3_next_addr", bus_address, 32'h0000_3000);
    bus_ready = 1'b1;
    bus_rdata = 32'h1234_5678;
    tick();
    bus_ready  = 1'b0;
    ch_request = 4'b0000;
    check("t3_next_ready", ch_ready, 4'b1000);
    check("t3_next_rdata", ch_rdata, 32'h1234_5678);
    check("t3_count_stable", timeout_count, 16'd1);
    tick();

    // ---- ready on the last allowed cycle counts as normal completion
    ch_request    = 4'b0001;
    ch_address[0] = 32'h0000_4000;
    tick();
    check("t4_grant", grant, 2'd0);
    for (int i = 2; i <= TIMEOUT; i++) tick();
    check("t4_req_last_cycle", bus_request, 1'b1);
    bus_ready = 1'b1;
    bus_rdata = 32'hBEEF_CAFE;
    tick();
    bus_ready  = 1'b0;
    ch_request = 4'b0000;
    check("t4_no_timeout", timeout, 1'b0);
    check("t4_rdata", ch_rdata, 32'hBEEF_CAFE);
    check("t4_count", timeout_count, 16'd1);
    check("t4_ch_ready", ch_ready, 4'b0001);
    tick();
    // stray bus ready while idle
    bus_ready = 1'b1;
    bus_rdata = 32'h1111_1111;
    tick();
    bus_ready = 1'b0;
    check("t4_stray_ready", ch_ready, 4'b0000);
    check("t4_stray_rdata", ch_rdata, 32'hBEEF_CAFE);
    check("t4_stray_state", dbg_state, IDLE);

    // ---- enable dropped during BUS
    ch_request    = 4'b0110;
    ch_address[1] = 32'h0000_5000;
    ch_address[2] = 32'h0000_6000;
    tick();
    check("t5_grant", grant, 2'd1);
    i_enable = 1'b0;
    tick();
    bus_ready = 1'b1;
    bus_rdata = 32'h55AA_55AA;
    tick();
    bus_ready = 1'b0;
    check("t5_ch_ready", ch_ready, 4'b0010);
    check("t5_rdata", ch_rdata, 32'h55AA_55AA);
    for (int i = 0; i < 5; i++) tick();
    check("t5_no_grant", bus_request, 1'b0);
    check("t5_idle", dbg_state, IDLE);
    i_enable = 1'b1;
    tick();
    check("t5_reenable_req", bus_request, 1'b1);
    check("t5_reenable_grant", grant, 2'd2);
    check("t5_reenable_addr", bus_address, 32'h0000_6000);

    // ---- asynchronous reset in the middle of a BUS cycle
    #3;
    i_reset = 1'b1;
    #1;
    check("t6_async_req", bus_request, 1'b0);
    check("t6_async_addr", bus_address, 32'h0);
    check("t6_async_grant", grant, 2'd0);
    check("t6_async_rdata", ch_rdata, 32'h0);
    check("t6_async_count", timeout_count, 16'h0);
    check("t6_async_state", dbg_state, IDLE);
    ch_request    = 4'b0101;
    ch_address[0] = 32'h0000_7000;
    tick();
    check("t6_no_ready", ch_ready, 4'b0000);
    i_reset = 1'b0;
    tick();
    check("t6_first_req", bus_request, 1'b1);
    check("t6_first_grant", grant, 2'd0);
    check("t6_first_addr", bus_address, 32'h0000_7000);
    bus_ready = 1'b1;
    bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ready  = 1'b0;
    ch_request = 4'b0000;
    check("t6_ready", ch_ready, 4'b0001);
    check("t6_rdata", ch_rdata, 32'h0BAD_F00D);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
